// File: rtl/easyaxi_rd_mst_ost.sv
// Command-driven AXI read master with OST_DEPTH outstanding slots and in-order replay of R data.
// Optional command legality check: define EASYAXI_RD_CMD_CHK_EN.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

package easyaxi_rd_mst_ost_pkg;
    localparam int unsigned ADDR_W  = `AXI_ADDR_W;
    localparam int unsigned LEN_W   = `AXI_LEN_W;
    localparam int unsigned SIZE_W  = `AXI_SIZE_W;
    localparam int unsigned BURST_W = `AXI_BURST_W;
    localparam int unsigned ID_W    = `AXI_ID_W;
    localparam int unsigned DATA_W  = `AXI_DATA_W;
    localparam int unsigned RESP_W  = `AXI_RESP_W;

    // Descriptor held per slot; drives the AR payload directly.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } cmd_t;

    // One buffered R beat.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
    } beat_t;
endpackage

module easyaxi_rd_mst_ost
    import easyaxi_rd_mst_ost_pkg::*;
#(
    parameter int unsigned OST_DEPTH     = 8,
    parameter int unsigned MAX_BURST_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [SIZE_W-1:0]  cmd_size,
    input  logic [BURST_W-1:0] cmd_burst,

    output logic               axi_mst_arvalid,
    input  logic               axi_mst_arready,
    output logic [ID_W-1:0]    axi_mst_arid,
    output logic [ADDR_W-1:0]  axi_mst_araddr,
    output logic [LEN_W-1:0]   axi_mst_arlen,
    output logic [SIZE_W-1:0]  axi_mst_arsize,
    output logic [BURST_W-1:0] axi_mst_arburst,

    input  logic               axi_mst_rvalid,
    output logic               axi_mst_rready,
    input  logic [ID_W-1:0]    axi_mst_rid,
    input  logic [DATA_W-1:0]  axi_mst_rdata,
    input  logic [RESP_W-1:0]  axi_mst_rresp,
    input  logic               axi_mst_rlast,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RESP_W-1:0]  out_resp,
    output logic               out_last,

    output logic               busy,
    output logic               error
);

    localparam int unsigned OST_CNT_W = $clog2(OST_DEPTH);
    localparam int unsigned IDX_W     = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;
    localparam int unsigned CNT_W     = $clog2(MAX_BURST_LEN) + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(MAX_BURST_LEN);
    localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2);

    logic [OST_DEPTH-1:0] valid_q, valid_d;
    logic [OST_DEPTH-1:0] ar_pend_q, ar_pend_d;
    logic [OST_DEPTH-1:0] data_done_q, data_done_d;
    logic [OST_DEPTH-1:0] illegal_q, illegal_d;
    cmd_t                 cmd_q    [OST_DEPTH];
    cmd_t                 cmd_d    [OST_DEPTH];
    logic [CNT_W-1:0]     wr_cnt_q [OST_DEPTH];
    logic [CNT_W-1:0]     wr_cnt_d [OST_DEPTH];
    logic [CNT_W-1:0]     rd_cnt_q [OST_DEPTH];
    logic [CNT_W-1:0]     rd_cnt_d [OST_DEPTH];
    logic [OST_CNT_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [OST_CNT_W-1:0] ar_ptr_q, ar_ptr_d;
    logic [OST_CNT_W-1:0] ret_ptr_q, ret_ptr_d;
    logic                 error_q, error_d;
    beat_t                buf_q [OST_DEPTH][MAX_BURST_LEN];

    logic                 cmd_fire;
    logic                 cmd_illegal_c;
    logic                 len_trunc;
    logic                 ar_fire;
    logic                 ar_skip;
    cmd_t                 ar_cmd;
    logic [OST_CNT_W-1:0] r_slot;
    logic                 r_in_range;
    logic                 r_ok;
    logic                 r_room;
    logic                 buf_we;
    logic [IDX_W-1:0]     buf_widx;
    logic [CNT_W-1:0]     ret_rd;
    logic [CNT_W-1:0]     ret_wr;
    logic [CNT_W-1:0]     ret_len;
    beat_t                ret_beat;
    logic                 out_fire;

`ifdef EASYAXI_RD_CMD_CHK_EN
    localparam logic [BURST_W-1:0] BURST_INCR = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_WRAP = BURST_W'(2);

    logic [ADDR_W-1:0] size_mask;
    logic [16:0]       incr_end;
    logic              wrap_len_ok;

    // Reject malformed WRAP bursts and INCR bursts that cross a 4KB page.
    always_comb begin
        size_mask     = ~({ADDR_W{1'b1}} << cmd_size);
        incr_end      = 17'(cmd_addr[11:0]) + ((17'(cmd_len) + 17'd1) << cmd_size);
        wrap_len_ok   = (cmd_len == LEN_W'(1)) || (cmd_len == LEN_W'(3)) ||
                        (cmd_len == LEN_W'(7)) || (cmd_len == LEN_W'(15));
        cmd_illegal_c = 1'b0;
        if (cmd_burst == BURST_WRAP) begin
            cmd_illegal_c = !wrap_len_ok || ((cmd_addr & size_mask) != '0);
        end else if (cmd_burst == BURST_INCR) begin
            cmd_illegal_c = incr_end > 17'd4096;
        end
    end
`else
    assign cmd_illegal_c = 1'b0;
`endif

    assign cmd_ready      = ~valid_q[alloc_ptr_q];
    assign cmd_fire       = cmd_valid & cmd_ready;
    assign len_trunc      = cmd_len > LEN_MAX;

    assign ar_cmd          = cmd_q[ar_ptr_q];
    assign axi_mst_arvalid = ar_pend_q[ar_ptr_q] & ~illegal_q[ar_ptr_q];
    assign ar_skip         = ar_pend_q[ar_ptr_q] & illegal_q[ar_ptr_q];
    assign ar_fire         = axi_mst_arvalid & axi_mst_arready;
    assign axi_mst_arid    = ID_W'(ar_ptr_q);
    assign axi_mst_araddr  = ar_cmd.addr;
    assign axi_mst_arlen   = ar_cmd.len;
    assign axi_mst_arsize  = ar_cmd.size;
    assign axi_mst_arburst = ar_cmd.burst;

    // Space for a whole burst is reserved at allocation, so R is never back-pressured.
    assign axi_mst_rready = 1'b1;
    assign r_slot         = axi_mst_rid[OST_CNT_W-1:0];
    assign r_in_range     = 32'(axi_mst_rid) < OST_DEPTH;
    assign r_ok           = r_in_range & valid_q[r_slot] & ~ar_pend_q[r_slot] & ~data_done_q[r_slot];
    assign r_room         = wr_cnt_q[r_slot] < CNT_FULL;
    assign buf_we         = axi_mst_rvalid & r_ok & r_room;
    assign buf_widx       = IDX_W'(wr_cnt_q[r_slot]);

    assign ret_rd    = rd_cnt_q[ret_ptr_q];
    assign ret_wr    = wr_cnt_q[ret_ptr_q];
    assign ret_len   = CNT_W'(cmd_q[ret_ptr_q].len);
    assign ret_beat  = buf_q[ret_ptr_q][IDX_W'(ret_rd)];
    assign out_valid = valid_q[ret_ptr_q] &
                       ((ret_rd < ret_wr) | (data_done_q[ret_ptr_q] & (ret_rd <= ret_len)));
    assign out_last  = ret_rd == ret_len;
    assign out_data  = illegal_q[ret_ptr_q] ? '0 : ret_beat.data;
    assign out_resp  = illegal_q[ret_ptr_q] ? RESP_SLVERR : ret_beat.resp;
    assign out_fire  = out_valid & out_ready;

    assign busy  = |valid_q;
    assign error = error_q;

    // Slot bookkeeping: allocate, issue, collect, retire.
    always_comb begin
        valid_d     = valid_q;
        ar_pend_d   = ar_pend_q;
        data_done_d = data_done_q;
        illegal_d   = illegal_q;
        cmd_d       = cmd_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        alloc_ptr_d = alloc_ptr_q;
        ar_ptr_d    = ar_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        error_d     = error_q;

        if (cmd_fire) begin
            cmd_d[alloc_ptr_q].addr  = cmd_addr;
            cmd_d[alloc_ptr_q].len   = len_trunc ? LEN_MAX : cmd_len;
            cmd_d[alloc_ptr_q].size  = cmd_size;
            cmd_d[alloc_ptr_q].burst = cmd_burst;
            valid_d[alloc_ptr_q]     = 1'b1;
            ar_pend_d[alloc_ptr_q]   = 1'b1;
            data_done_d[alloc_ptr_q] = cmd_illegal_c;
            illegal_d[alloc_ptr_q]   = cmd_illegal_c;
            wr_cnt_d[alloc_ptr_q]    = '0;
            rd_cnt_d[alloc_ptr_q]    = '0;
            alloc_ptr_d              = alloc_ptr_q + OST_CNT_W'(1);
            if (len_trunc || cmd_illegal_c) begin
                error_d = 1'b1;
            end
        end

        // Illegal slots leave the AR queue without a handshake.
        if (ar_fire || ar_skip) begin
            ar_pend_d[ar_ptr_q] = 1'b0;
            ar_ptr_d            = ar_ptr_q + OST_CNT_W'(1);
        end

        if (axi_mst_rvalid) begin
            if (!r_ok) begin
                error_d = 1'b1;
            end else begin
                if (r_room) begin
                    wr_cnt_d[r_slot] = wr_cnt_q[r_slot] + CNT_W'(1);
                end else begin
                    error_d = 1'b1;
                end
                if (axi_mst_rlast != (wr_cnt_q[r_slot] == CNT_W'(cmd_q[r_slot].len))) begin
                    error_d = 1'b1;
                end
                if (axi_mst_rlast) begin
                    data_done_d[r_slot] = 1'b1;
                end
            end
            if (axi_mst_rresp[1]) begin
                error_d = 1'b1;
            end
        end

        if (out_fire) begin
            rd_cnt_d[ret_ptr_q] = ret_rd + CNT_W'(1);
            if (out_last) begin
                valid_d[ret_ptr_q] = 1'b0;
                ret_ptr_d          = ret_ptr_q + OST_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            ar_pend_q   <= '0;
            data_done_q <= '0;
            illegal_q   <= '0;
            alloc_ptr_q <= '0;
            ar_ptr_q    <= '0;
            ret_ptr_q   <= '0;
            error_q     <= 1'b0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                cmd_q[i]    <= '0;
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            ar_pend_q   <= ar_pend_d;
            data_done_q <= data_done_d;
            illegal_q   <= illegal_d;
            alloc_ptr_q <= alloc_ptr_d;
            ar_ptr_q    <= ar_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            error_q     <= error_d;
            cmd_q       <= cmd_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Per-slot beat storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                for (int j = 0; j < MAX_BURST_LEN; j++) begin
                    buf_q[i][j] <= '0;
                end
            end
        end else if (buf_we) begin
            buf_q[r_slot][buf_widx] <= {axi_mst_rdata, axi_mst_rresp};
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_mst_ost.sv
// Directed bench for easyaxi_rd_mst_ost: vector table of single bursts plus multi-slot sequences.
`timescale 1ns/1ps

module tb_easyaxi_rd_mst_ost;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        axi_mst_arvalid;
    logic        axi_mst_arready = 1'b1;
    logic [3:0]  axi_mst_arid;
    logic [31:0] axi_mst_araddr;
    logic [7:0]  axi_mst_arlen;
    logic [2:0]  axi_mst_arsize;
    logic [1:0]  axi_mst_arburst;
    logic        axi_mst_rvalid = 1'b0;
    logic        axi_mst_rready;
    logic [3:0]  axi_mst_rid = '0;
    logic [31:0] axi_mst_rdata = '0;
    logic [1:0]  axi_mst_rresp = '0;
    logic        axi_mst_rlast = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last;
    logic        busy;
    logic        error;

    easyaxi_rd_mst_ost #(.OST_DEPTH(8), .MAX_BURST_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .axi_mst_arvalid(axi_mst_arvalid), .axi_mst_arready(axi_mst_arready),
        .axi_mst_arid(axi_mst_arid), .axi_mst_araddr(axi_mst_araddr),
        .axi_mst_arlen(axi_mst_arlen), .axi_mst_arsize(axi_mst_arsize),
        .axi_mst_arburst(axi_mst_arburst),
        .axi_mst_rvalid(axi_mst_rvalid), .axi_mst_rready(axi_mst_rready),
        .axi_mst_rid(axi_mst_rid), .axi_mst_rdata(axi_mst_rdata),
        .axi_mst_rresp(axi_mst_rresp), .axi_mst_rlast(axi_mst_rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_resp(out_resp), .out_last(out_last),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_rec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } out_rec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] dbase;
        logic [1:0]  resp;
        logic [3:0]  exp_id;
        logic        exp_err;
    } vec_t;

    ar_rec_t  ar_q[$];
    out_rec_t out_q[$];
    int       n_chk = 0;
    int       n_fail = 0;

    // Handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && axi_mst_arvalid && axi_mst_arready)
            ar_q.push_back({axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst});
        if (rst_n && out_valid && out_ready)
            out_q.push_back({out_data, out_resp, out_last});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got no handshake, required one within the cycle budget", name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        axi_mst_arready = 1'b1;
        axi_mst_rvalid = 1'b0;
        axi_mst_rlast = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        ar_q.delete();
        out_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        cmd_size = s;
        cmd_burst = b;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) fail_timeout("cmd_accept");
        else tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_r(input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] r, input logic l);
        axi_mst_rvalid = 1'b1;
        axi_mst_rid = id;
        axi_mst_rdata = d;
        axi_mst_rresp = r;
        axi_mst_rlast = l;
        tick();
        axi_mst_rvalid = 1'b0;
        axi_mst_rlast = 1'b0;
    endtask

    task automatic respond(input logic [3:0] id, input int len,
                           input logic [31:0] base, input logic [1:0] r);
        for (int k = 0; k <= len; k++) send_r(id, base + 32'(k), r, k == len);
    endtask

    task automatic wait_ar(output ar_rec_t a, output bit ok);
        int n = 0;
        while (ar_q.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        ok = ar_q.size() != 0;
        a = '0;
        if (ok) a = ar_q.pop_front();
        else fail_timeout("ar_wait");
    endtask

    task automatic wait_out(input int cnt);
        int n = 0;
        while (out_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        if (out_q.size() < cnt) fail_timeout("out_wait");
    endtask

    vec_t     vecs[6];
    ar_rec_t  a;
    out_rec_t o;
    bit       ok;

    initial begin
        vecs[0] = '{32'h10,   8'd3, 3'd2, 2'd1, 32'hA0,   2'd0, 4'd0, 1'b0};
        vecs[1] = '{32'h100,  8'd0, 3'd2, 2'd1, 32'hB0,   2'd0, 4'd1, 1'b0};
        vecs[2] = '{32'h2000, 8'd7, 3'd2, 2'd1, 32'h1000, 2'd0, 4'd2, 1'b0};
        vecs[3] = '{32'h40,   8'd1, 3'd3, 2'd0, 32'h55,   2'd0, 4'd3, 1'b0};
        vecs[4] = '{32'h80,   8'd3, 3'd2, 2'd2, 32'h77,   2'd0, 4'd4, 1'b0};
        vecs[5] = '{32'h300,  8'd1, 3'd2, 2'd1, 32'h99,   2'd2, 4'd5, 1'b1};

        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rready", axi_mst_rready, 1);
        check("rst_arvalid", axi_mst_arvalid, 0);
        check("rst_araddr", axi_mst_araddr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);

        // Table: one burst at a time, slots used in order.
        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
            wait_ar(a, ok);
            check("vec_arid", a.id, vecs[i].exp_id);
            check("vec_araddr", a.addr, vecs[i].addr);
            check("vec_arlen", a.len, vecs[i].len);
            check("vec_arsize", a.size, vecs[i].size);
            check("vec_arburst", a.burst, vecs[i].burst);
            respond(vecs[i].exp_id, int'(vecs[i].len), vecs[i].dbase, vecs[i].resp);
            wait_out(int'(vecs[i].len) + 1);
            for (int k = 0; k <= int'(vecs[i].len); k++) begin
                if (out_q.size() != 0) begin
                    o = out_q.pop_front();
                    check("vec_out_data", o.data, vecs[i].dbase + 32'(k));
                    check("vec_out_resp", o.resp, vecs[i].resp);
                    check("vec_out_last", o.last, k == int'(vecs[i].len));
                end
            end
            check("vec_error", error, vecs[i].exp_err);
            check("vec_busy_idle", busy, 0);
        end

        // Accept-to-arvalid latency and AR payload stability under arready=0.
        do_reset();
        axi_mst_arready = 1'b0;
        send_cmd(32'h440, 8'd0, 3'd2, 2'd1);
        check("lat_arvalid", axi_mst_arvalid, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_arvalid", axi_mst_arvalid, 1);
            check("hold_araddr", axi_mst_araddr, 32'h440);
        end
        axi_mst_arready = 1'b1;
        wait_ar(a, ok);
        check("hold_arid", a.id, 0);
        respond(4'd0, 0, 32'h5A, 2'd0);
        wait_out(1);
        if (out_q.size() != 0) begin
            o = out_q.pop_front();
            check("hold_out_data", o.data, 32'h5A);
        end

        // Fill all 8 slots; the 9th command waits for the first retire and reuses slot 0.
        do_reset();
        for (int i = 0; i < 8; i++) send_cmd(32'h1000 + 32'(i * 16), 8'd0, 3'd2, 2'd1);
        for (int i = 0; i < 8; i++) begin
            wait_ar(a, ok);
            check("full_arid", a.id, 4'(i));
        end
        cmd_valid = 1'b1;
        cmd_addr = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            check("full_cmd_ready", cmd_ready, 0);
            tick();
        end
        send_r(4'd0, 32'hD0, 2'd0, 1'b1);
        send_cmd(32'h2000, 8'd0, 3'd2, 2'd1);
        check("full_first_out", out_q.size(), 1);
        wait_ar(a, ok);
        check("ninth_arid", a.id, 0);
        check("ninth_araddr", a.addr, 32'h2000);
        for (int i = 1; i < 8; i++) send_r(4'(i), 32'hD0 + 32'(i), 2'd0, 1'b1);
        send_r(4'd0, 32'hD8, 2'd0, 1'b1);
        wait_out(9);
        for (int i = 0; i < 9; i++) begin
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("full_out_data", o.data, 32'hD0 + 32'(i));
            end
        end
        check("full_error", error, 0);

        // Out-of-order R across IDs 2,0,1 replays in command order.
        do_reset();
        for (int i = 0; i < 3; i++) send_cmd(32'h600 + 32'(i * 4), 8'd0, 3'd2, 2'd1);
        for (int i = 0; i < 3; i++) begin
            wait_ar(a, ok);
            check("ooo_arid", a.id, 4'(i));
        end
        send_r(4'd2, 32'hC2, 2'd0, 1'b1);
        tick();
        check("ooo_hold", out_q.size(), 0);
        send_r(4'd0, 32'hC0, 2'd0, 1'b1);
        send_r(4'd1, 32'hC1, 2'd0, 1'b1);
        wait_out(3);
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("ooo_out_data", o.data, 32'hC0 + 32'(i));
            end
        end

        // Back-pressure on the user side during a len-7 burst; cut-through after the first beat.
        do_reset();
        out_ready = 1'b0;
        send_cmd(32'h800, 8'd7, 3'd2, 2'd1);
        wait_ar(a, ok);
        for (int k = 0; k < 8; k++) begin
            check("bp_rready", axi_mst_rready, 1);
            send_r(4'd0, 32'hE0 + 32'(k), 2'd0, k == 7);
            if (k == 0) check("bp_cut_through", out_valid, 1);
        end
        for (int k = 0; k < 20; k++) tick();
        check("bp_no_out", out_q.size(), 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_out(8);
        for (int k = 0; k < 8; k++) begin
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("bp_out_data", o.data, 32'hE0 + 32'(k));
                check("bp_out_last", o.last, k == 7);
            end
        end
        check("bp_error", error, 0);

        // R beat to a free slot sets sticky error.
        do_reset();
        check("err_pre", error, 0);
        send_r(4'd5, 32'h11, 2'd0, 1'b1);
        check("err_free_slot", error, 1);
        for (int k = 0; k < 5; k++) tick();
        check("err_sticky", error, 1);
        do_reset();
        check("err_cleared", error, 0);

        // Early rlast on beat 2 of a len-3 burst.
        send_cmd(32'h900, 8'd3, 3'd2, 2'd1);
        wait_ar(a, ok);
        send_r(4'd0, 32'hF0, 2'd0, 1'b0);
        check("err_early_pre", error, 0);
        send_r(4'd0, 32'hF1, 2'd0, 1'b1);
        check("err_early_last", error, 1);
        wait_out(4);
        check("err_early_beats", out_q.size(), 4);
        check("err_early_idle", busy, 0);

        // Over-long command is truncated on AR and flags error.
        do_reset();
        send_cmd(32'hA00, 8'd10, 3'd2, 2'd1);
        wait_ar(a, ok);
        check("trunc_arlen", a.len, 7);
        check("trunc_error", error, 1);
        respond(4'd0, 7, 32'h300, 2'd0);
        wait_out(8);
        for (int k = 0; k < 8; k++) begin
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("trunc_out_last", o.last, k == 7);
            end
        end

`ifdef EASYAXI_RD_CMD_CHK_EN
        // Illegal commands consume a slot, issue no AR, and replay SLVERR zeros.
        do_reset();
        send_cmd(32'h34, 8'd2, 3'd2, 2'd2);
        for (int k = 0; k < 5; k++) tick();
        check("chk_no_ar", ar_q.size(), 0);
        wait_out(3);
        for (int k = 0; k < 3; k++) begin
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("chk_out_data", o.data, 0);
                check("chk_out_resp", o.resp, 2);
                check("chk_out_last", o.last, k == 2);
            end
        end
        check("chk_error", error, 1);
        send_cmd(32'hFF0, 8'd7, 3'd2, 2'd1);
        wait_out(8);
        check("chk_4k_no_ar", ar_q.size(), 0);
        out_q.delete();
        send_cmd(32'h200, 8'd0, 3'd2, 2'd1);
        wait_ar(a, ok);
        check("chk_skip_arid", a.id, 2);
        respond(4'd2, 0, 32'h77, 2'd0);
        wait_out(1);
        if (out_q.size() != 0) begin
            o = out_q.pop_front();
            check("chk_legal_data", o.data, 32'h77);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
